// File: rtl/mux_pkg.sv
//------------------------------------------------------------------------------
// Module : mux_pkg
// Brief  : Shared FSM state encoding and mode constants for the scan mux.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_next_ch.sv
//------------------------------------------------------------------------------
// Module : rr_next_ch
// Brief  : Finds the next enabled channel strictly above i_cur, wrapping past
//          NUM_CH-1 to 0 (i_cur itself is the last candidate).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_next_ch #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         i_mask,
    input  logic [$clog2(NUM_CH)-1:0] i_cur,
    output logic [$clog2(NUM_CH)-1:0] o_next
);

    localparam int SEL_W = $clog2(NUM_CH);

    logic [SEL_W-1:0] w_idx;

    // Walk from the farthest offset down so the nearest enabled hit wins.
    always_comb begin
        o_next = i_cur;
        w_idx  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = SEL_W'((int'(i_cur) + i) % NUM_CH);
            if (i_mask[w_idx]) begin
                o_next = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_nx1_scan.sv
//------------------------------------------------------------------------------
// Module : mux_nx1_scan
// Brief  : N:1 registered mux with manual select and auto-scan over an
//          enabled-channel mask, sampling each channel after DWELL cycles.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_nx1_scan #(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    parameter  int DWELL  = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    start,
    output logic [WIDTH-1:0]        dout,
    output logic [SEL_W-1:0]        ch_idx,
    output logic                    dout_valid,
    output logic                    busy
);

    import mux_pkg::*;

    localparam int              DW_W         = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] c_dwell_last = DW_W'(DWELL - 1);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_cur, w_cur_nxt;
    logic [SEL_W-1:0] r_ch_idx, w_ch_idx_nxt;
    logic [DW_W-1:0]  r_dwell_cnt, w_dwell_nxt;
    logic [WIDTH-1:0] r_dout, w_dout_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy;

    logic [SEL_W-1:0] w_next_en, w_first_en, w_man_idx;
    logic [WIDTH-1:0] w_din_cur, w_man_dout;
    logic             w_sel_ok, w_any_en;

    assign w_sel_ok   = int'(sel) < NUM_CH;
    assign w_any_en   = |ch_en;
    assign w_din_cur  = din[int'(r_cur) * WIDTH +: WIDTH];
    assign w_man_dout = w_sel_ok ? din[int'(sel) * WIDTH +: WIDTH] : '0;
    assign w_man_idx  = w_sel_ok ? sel : r_ch_idx;

    rr_next_ch #(.NUM_CH(NUM_CH)) u_next_en (
        .i_mask (ch_en),
        .i_cur  (r_cur),
        .o_next (w_next_en)
    );

    // Searching "above NUM_CH-1" with wrap yields the lowest enabled index.
    rr_next_ch #(.NUM_CH(NUM_CH)) u_first_en (
        .i_mask (ch_en),
        .i_cur  (SEL_W'(NUM_CH - 1)),
        .o_next (w_first_en)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_dwell_nxt  = r_dwell_cnt;
        w_dout_nxt   = r_dout;
        w_ch_idx_nxt = r_ch_idx;
        w_valid_nxt  = 1'b0;

        if (mode == MODE_MANUAL) begin
            w_state_nxt  = ST_IDLE;
            w_dout_nxt   = w_man_dout;
            w_ch_idx_nxt = w_man_idx;
            w_valid_nxt  = w_sel_ok;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && w_any_en) begin
                        w_state_nxt = ST_SCAN;
                        w_cur_nxt   = w_first_en;
                        w_dwell_nxt = '0;
                    end
                end
                ST_SCAN: begin
                    if (!w_any_en) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!ch_en[r_cur]) begin
                        // Current channel dropped out: skip it without sampling.
                        w_cur_nxt   = w_next_en;
                        w_dwell_nxt = '0;
                    end else if (r_dwell_cnt == c_dwell_last) begin
                        w_dout_nxt   = w_din_cur;
                        w_ch_idx_nxt = r_cur;
                        w_valid_nxt  = 1'b1;
                        w_cur_nxt    = w_next_en;
                        w_dwell_nxt  = '0;
                    end else begin
                        w_dwell_nxt = r_dwell_cnt + DW_W'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_dwell_cnt <= '0;
            r_dout      <= '0;
            r_ch_idx    <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_dout      <= w_dout_nxt;
            r_ch_idx    <= w_ch_idx_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= (w_state_nxt == ST_SCAN);
        end
    end

    assign dout       = r_dout;
    assign ch_idx     = r_ch_idx;
    assign dout_valid = r_valid;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mux_nx1_scan.sv
//------------------------------------------------------------------------------
// Module : tb_mux_nx1_scan
// Brief  : Self-checking bench for mux_nx1_scan (WIDTH=8, NUM_CH=4, DWELL=4).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mux_nx1_scan;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int DWELL  = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din   = 32'hDDCC_BBAA;
    logic        mode  = 1'b0;
    logic [1:0]  sel   = 2'd2;
    logic [3:0]  ch_en = 4'b0000;
    logic        start = 1'b0;
    logic [7:0]  dout;
    logic [1:0]  ch_idx;
    logic        dout_valid;
    logic        busy;

    mux_nx1_scan #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .mode       (mode),
        .sel        (sel),
        .ch_en      (ch_en),
        .start      (start),
        .dout       (dout),
        .ch_idx     (ch_idx),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] dout;
        logic [1:0] idx;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    bit   mon_en = 1'b0;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] en;
        logic       start;
        logic [7:0] e_dout;
        logic [1:0] e_idx;
        logic       e_valid;
        logic       e_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] i, input int c);
        exp_t e;
        e.dout = d;
        e.idx  = i;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // Every sample pulse must match the next queued expectation, including its cycle.
    always @(negedge clk) begin
        if (mon_en && dout_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", int'(dout_valid), 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("scan_dout", int'(dout), int'(e.dout));
                check("scan_ch_idx", int'(ch_idx), int'(e.idx));
                check("scan_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c0;

        tbl[0] = '{1'b0, 2'd0, 4'h0, 1'b0, 8'hAA, 2'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 2'd1, 4'h0, 1'b0, 8'hBB, 2'd1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 2'd2, 4'h0, 1'b0, 8'hCC, 2'd2, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 2'd3, 4'h0, 1'b0, 8'hDD, 2'd3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 2'd0, 4'h0, 1'b0, 8'hDD, 2'd3, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'd0, 4'h0, 1'b1, 8'hDD, 2'd3, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 2'd1, 4'hF, 1'b1, 8'hBB, 2'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 2'd2, 4'hF, 1'b0, 8'hCC, 2'd2, 1'b1, 1'b0};

        // Reset held with manual sel=2, then released between edges.
        tick();
        tick();
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_ch_idx", int'(ch_idx), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_dout", int'(dout), 'hCC);
        check("rel_ch_idx", int'(ch_idx), 2);
        check("rel_valid", int'(dout_valid), 1);

        for (int i = 0; i < 8; i++) begin
            mode  = tbl[i].mode;
            sel   = tbl[i].sel;
            ch_en = tbl[i].en;
            start = tbl[i].start;
            tick();
            start = 1'b0;
            check($sformatf("vec%0d_dout", i), int'(dout), int'(tbl[i].e_dout));
            check($sformatf("vec%0d_ch_idx", i), int'(ch_idx), int'(tbl[i].e_idx));
            check($sformatf("vec%0d_valid", i), int'(dout_valid), int'(tbl[i].e_valid));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
        end

        // Full scan over all four channels.
        mode  = 1'b1;
        ch_en = 4'b1111;
        start = 1'b1;
        c0    = cyc;
        push(8'hAA, 2'd0, c0 + 5);
        push(8'hBB, 2'd1, c0 + 9);
        push(8'hCC, 2'd2, c0 + 13);
        push(8'hDD, 2'd3, c0 + 17);
        push(8'hAA, 2'd0, c0 + 21);
        tick();
        start  = 1'b0;
        mon_en = 1'b1;
        check("scan1_busy", int'(busy), 1);
        run_until(c0 + 21);
        ch_en = 4'b0000;
        tick();
        check("scan1_stop_busy", int'(busy), 0);
        check("scan1_stop_valid", int'(dout_valid), 0);
        check("scan1_drained", sbq.size(), 0);

        // Sparse mask 1010: channels 1 and 3 only.
        ch_en = 4'b1010;
        start = 1'b1;
        c0    = cyc;
        push(8'hBB, 2'd1, c0 + 5);
        push(8'hDD, 2'd3, c0 + 9);
        push(8'hBB, 2'd1, c0 + 13);
        tick();
        start = 1'b0;
        check("scan2_busy", int'(busy), 1);
        run_until(c0 + 13);
        ch_en = 4'b0000;
        tick();
        check("scan2_stop_busy", int'(busy), 0);
        check("scan2_drained", sbq.size(), 0);

        // Channel 1 disabled partway through its dwell: it is skipped.
        ch_en = 4'b1111;
        start = 1'b1;
        c0    = cyc;
        push(8'hAA, 2'd0, c0 + 5);
        push(8'hCC, 2'd2, c0 + 11);
        push(8'hDD, 2'd3, c0 + 15);
        push(8'hAA, 2'd0, c0 + 19);
        tick();
        start = 1'b0;
        run_until(c0 + 6);
        ch_en = 4'b1101;
        run_until(c0 + 20);
        check("scan3_drained", sbq.size(), 0);

        // Reset in the middle of a scan.
        run_until(c0 + 21);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_ch_idx", int'(ch_idx), 0);
        check("midrst_valid", int'(dout_valid), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("postrst_busy", int'(busy), 0);
        check("postrst_valid", int'(dout_valid), 0);
        check("postrst_dout", int'(dout), 0);
        check("postrst_ch_idx", int'(ch_idx), 0);

        // A fresh start after reset scans again from the lowest enabled channel.
        start = 1'b1;
        c0    = cyc;
        push(8'hAA, 2'd0, c0 + 5);
        tick();
        start = 1'b0;
        check("restart_busy", int'(busy), 1);
        run_until(c0 + 6);
        check("restart_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
